// File: rtl/debug_player_pkg.sv
// Shared types and helpers for the debug player and capture buffer.
// Holds the FSM state encoding and the address-width helper.
package debug_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/debug_player_pb_edge.sv
// One-flop rising-edge detector for raw push-buttons.
// rise is high in the cycle d is first seen high.
module pb_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic q;

  // remember last sampled button level
  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/debug_player.sv
// Debug stimulus player: load samples from switches, replay on trigger.
// Define DEBUG_PLAYER_LOOP_EN for continuous looping playback.
module debug_player
  import debug_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             trg,
  input  logic             choice_in,
  input  logic             wr_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [AW-1:0]    addr_out,
  output logic [WIDTH-1:0] view_out,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done
);

`ifdef DEBUG_PLAYER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] ZERO = '0;

  logic [WIDTH-1:0] mem [DEPTH];
  state_t           state, state_n;
  logic [AW-1:0]    ea, ea_n, pi, pi_n;
  logic [WIDTH-1:0] dout_n;
  logic             done_n, wr, ce, we;
  logic             hold, hold_n;

  pb_edge u_ce (
    .clk  (clk),
    .rst  (rst),
    .d    (choice_in),
    .rise (ce)
  );

  pb_edge u_we (
    .clk  (clk),
    .rst  (rst),
    .d    (wr_in),
    .rise (we)
  );

  // next-state and datapath decode
  always_comb begin
    state_n = state;
    ea_n    = ea;
    pi_n    = pi;
    dout_n  = data_out;
    done_n  = 1'b0;
    wr      = 1'b0;
    hold_n  = hold;
    unique case (state)
      ST_IDLE: begin
        wr     = we;
        dout_n = '0;
        if (!trg) hold_n = 1'b0;
        if (ce) ea_n = ea + ONE;
        if (trg && !hold) begin
          state_n = ST_PLAY;
          pi_n    = '0;
          dout_n  = (we && ea == ZERO) ? data_in : mem[ZERO];
        end
      end
      ST_PLAY: begin
        if (LOOP && trg) begin
          state_n = ST_IDLE;
          pi_n    = '0;
          dout_n  = '0;
          hold_n  = 1'b1;
        end else if (en) begin
          if (pi == LAST) begin
            done_n = 1'b1;
            pi_n   = '0;
            if (LOOP) begin
              dout_n = mem[ZERO];
            end else begin
              state_n = ST_IDLE;
              dout_n  = '0;
            end
          end else begin
            pi_n   = pi + ONE;
            dout_n = mem[pi + ONE];
          end
        end
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // counters and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ea       <= '0;
      pi       <= '0;
      data_out <= '0;
      done     <= 1'b0;
      hold     <= 1'b0;
    end else begin
      ea       <= ea_n;
      pi       <= pi_n;
      data_out <= dout_n;
      done     <= done_n;
      hold     <= hold_n;
    end
  end

  // sample memory, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr) begin
      mem[ea] <= data_in;
    end
  end

  assign busy     = (state == ST_PLAY);
  assign addr_out = busy ? pi : ea;
  assign view_out = mem[ea];

endmodule

// File: tb/tb_debug_player.sv
// Scoreboard bench for debug_player (WIDTH=8, DEPTH=4).
// Stimulus queues expectations; a negedge monitor pops and compares.
module tb_debug_player;

`ifdef DEBUG_PLAYER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  localparam int S_ADDR = 0;
  localparam int S_VIEW = 1;
  localparam int S_DATA = 2;
  localparam int S_BUSY = 3;
  localparam int S_DONE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       trg = 1'b0;
  logic       choice_in = 1'b0;
  logic       wr_in = 1'b0;
  logic [7:0] data_in = '0;
  logic [1:0] addr_out;
  logic [7:0] view_out;
  logic [7:0] data_out;
  logic       busy;
  logic       done;

  debug_player #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .trg       (trg),
    .choice_in (choice_in),
    .wr_in     (wr_in),
    .data_in   (data_in),
    .addr_out  (addr_out),
    .view_out  (view_out),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    int         sig;
    logic [7:0] val;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] act(input int s);
    case (s)
      S_ADDR:  return {6'b0, addr_out};
      S_VIEW:  return view_out;
      S_DATA:  return data_out;
      S_BUSY:  return {7'b0, busy};
      default: return {7'b0, done};
    endcase
  endfunction

  function automatic string nm(input int s);
    case (s)
      S_ADDR:  return "addr_out";
      S_VIEW:  return "view_out";
      S_DATA:  return "data_out";
      S_BUSY:  return "busy";
      default: return "done";
    endcase
  endfunction

  // monitor: compare queued expectations at the falling edge
  initial begin
    exp_t       e;
    logic [7:0] got;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e   = q.pop_front();
        got = act(e.sig);
        checks++;
        if (got !== e.val || e.due != cyc) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h exp=%h",
                   nm(e.sig), cyc, got, e.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int s, input logic [7:0] v);
    q.push_back('{cyc, s, v});
  endtask

  task automatic ce_pulse();
    choice_in = 1'b1;
    tick();
    choice_in = 1'b0;
    tick();
  endtask

  task automatic write_all();
    for (int i = 0; i < 4; i++) begin
      data_in = vals[i];
      wr_in   = 1'b1;
      tick();
      wr_in = 1'b0;
      chk(S_VIEW, vals[i]);
      chk(S_ADDR, 8'(i));
      choice_in = 1'b1;
      tick();
      choice_in = 1'b0;
      chk(S_ADDR, 8'((i + 1) % 4));
    end
  endtask

  task automatic stop_loop();
`ifdef DEBUG_PLAYER_LOOP_EN
    trg = 1'b1;
    tick();
    trg = 1'b0;
    chk(S_BUSY, 8'h00);
    chk(S_DATA, 8'h00);
    chk(S_DONE, 8'h00);
`endif
  endtask

  initial begin
    // reset state
    tick();
    tick();
    rst = 1'b0;
    chk(S_ADDR, 8'h00);
    chk(S_VIEW, 8'h00);
    chk(S_DATA, 8'h00);
    chk(S_BUSY, 8'h00);
    chk(S_DONE, 8'h00);

    // load and read back, edit address wraps 3 -> 0
    write_all();
    chk(S_VIEW, 8'h11);

    // playback, en every third cycle
    trg = 1'b1;
    tick();
    trg = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        chk(S_DATA, vals[k]);
        chk(S_BUSY, 8'h01);
        chk(S_ADDR, 8'(k));
        chk(S_DONE, 8'h00);
        en = (j == 2);
        tick();
        en = 1'b0;
      end
    end
    chk(S_DONE, 8'h01);
    chk(S_BUSY, 8'(LOOP));
    chk(S_DATA, LOOP ? vals[0] : 8'h00);
    stop_loop();
    tick();
    chk(S_DONE, 8'h00);
    chk(S_BUSY, 8'h00);
    chk(S_DATA, 8'h00);

    // trg and wr edge during play are ignored
    trg = 1'b1;
    tick();
    trg = 1'b0;
    chk(S_DATA, 8'h11);
    en = 1'b1;
    tick();
    en = 1'b0;
    chk(S_DATA, 8'h22);
`ifndef DEBUG_PLAYER_LOOP_EN
    trg = 1'b1;
`endif
    wr_in   = 1'b1;
    data_in = 8'hEE;
    tick();
    trg   = 1'b0;
    wr_in = 1'b0;
    chk(S_DATA, 8'h22);
    chk(S_ADDR, 8'h01);
    chk(S_BUSY, 8'h01);
    en = 1'b1;
    tick();
    chk(S_DATA, 8'h33);
    tick();
    chk(S_DATA, 8'h44);
    tick();
    en = 1'b0;
    chk(S_DONE, 8'h01);
    chk(S_BUSY, 8'(LOOP));
    stop_loop();
    tick();
    chk(S_VIEW, 8'h11);
    chk(S_ADDR, 8'h00);

    // reset in the middle of playback
    trg = 1'b1;
    tick();
    trg = 1'b0;
    en  = 1'b1;
    tick();
    tick();
    en = 1'b0;
    chk(S_ADDR, 8'h02);
    chk(S_DATA, 8'h33);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk(S_BUSY, 8'h00);
    chk(S_DATA, 8'h00);
    chk(S_DONE, 8'h00);
    chk(S_ADDR, 8'h00);
    tick();
    chk(S_DONE, 8'h00);
    for (int a = 0; a < 4; a++) begin
      chk(S_VIEW, 8'h00);
      chk(S_ADDR, 8'(a));
      ce_pulse();
    end

    // simultaneous write and advance, then a held button
    ce_pulse();
    data_in   = 8'hA5;
    wr_in     = 1'b1;
    choice_in = 1'b1;
    tick();
    wr_in     = 1'b0;
    choice_in = 1'b0;
    chk(S_ADDR, 8'h02);
    chk(S_VIEW, 8'h00);
    tick();
    ce_pulse();
    ce_pulse();
    ce_pulse();
    chk(S_ADDR, 8'h01);
    chk(S_VIEW, 8'hA5);
    choice_in = 1'b1;
    tick();
    chk(S_ADDR, 8'h02);
    repeat (9) tick();
    chk(S_ADDR, 8'h02);
    choice_in = 1'b0;
    tick();
    chk(S_ADDR, 8'h02);

    // en every cycle: looping or level-trigger replay
    rst = 1'b1;
    tick();
    rst = 1'b0;
    write_all();
`ifdef DEBUG_PLAYER_LOOP_EN
    trg = 1'b1;
    tick();
    trg = 1'b0;
    chk(S_DATA, 8'h11);
    en = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk(S_DATA, vals[c % 4]);
      chk(S_DONE, 8'((c % 4) == 0));
      chk(S_BUSY, 8'h01);
    end
    en = 1'b0;
    stop_loop();
`else
    trg = 1'b1;
    en  = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk(S_DATA, (c <= 4) ? vals[c - 1] : (c == 6) ? 8'h11 : 8'h00);
      chk(S_BUSY, 8'(c != 5));
      chk(S_DONE, 8'(c == 5));
    end
    trg = 1'b0;
    en  = 1'b0;
`endif

    tick();
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
